timekeeper_core: RTL and testbench

Parametrised hour/min/sec/centisecond timekeeper for the stopwatch/watch display path. It generalises the fixed 100 Hz cascade with these additions:
- configurable clock and tick rates
- configurable hour range
- direct load
- per-field set with no carry
- stop-at-zero countdown
- lap capture
- alarm match
Output packing matches the existing 24-bit time bus consumed by the 4:1 display mux.

---
 rtl/timekeeper_core_if.sv | 34 +++
 rtl/timekeeper_core.sv | 212 +++++++++++++++++++++
 tb/tb_timekeeper_core.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timekeeper_core_if.sv
// Control and time bus between a timekeeper_core and its controller / display path.
// Time words use {hour[23:19], min[18:13], sec[12:7], csec[6:0]}; alarm uses {hour, min, sec}.
interface timekeeper_core_if;
   logic        run;
   logic        down;
   logic        clear;
   logic        load;
   logic [23:0] load_time;
   logic        set_en;
   logic [1:0]  set_field;
   logic        inc;
   logic        dec;
   logic        lap;
   logic        alarm_en;
   logic [16:0] alarm_time;
   logic [23:0] time_out;
   logic [23:0] lap_time;
   logic        lap_valid;
   logic        tick;
   logic        alarm_hit;
   logic        zero_reached;

   modport master (
      output run, down, clear, load, load_time, set_en, set_field, inc, dec, lap,
             alarm_en, alarm_time,
      input  time_out, lap_time, lap_valid, tick, alarm_hit, zero_reached
   );

   modport slave (
      input  run, down, clear, load, load_time, set_en, set_field, inc, dec, lap,
             alarm_en, alarm_time,
      output time_out, lap_time, lap_valid, tick, alarm_hit, zero_reached
   );
endinterface

// File: rtl/timekeeper_core.sv
// Parametrised hour/min/sec/centisecond timekeeper with load, set, countdown, lap and alarm.
// All outputs are registered; the whole carry/borrow chain settles in a single edge.
module timekeeper_core #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int TICK_HZ      = 100,
   parameter int HOUR_MAX     = 24,
   parameter int STOP_AT_ZERO = 1
) (
   input  logic             clk,
   input  logic             reset,
   timekeeper_core_if.slave tk
);
   localparam int              DIV      = CLK_HZ / TICK_HZ;
   localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
   localparam logic [6:0]      CSEC_TOP = 7'(TICK_HZ - 1);
   localparam logic [6:0]      SEC_TOP  = 7'd59;
   localparam logic [6:0]      HOUR_TOP = 7'(HOUR_MAX - 1);
   localparam logic            STOP_EN  = (STOP_AT_ZERO != 0);

   function automatic logic [6:0] step_up(input logic [6:0] v, input logic [6:0] top);
      logic [6:0] r;
      if (v >= top) begin
         r = 7'd0;
      end else begin
         r = v + 7'd1;
      end
      return r;
   endfunction

   function automatic logic [6:0] step_dn(input logic [6:0] v, input logic [6:0] top);
      logic [6:0] r;
      if (v == 7'd0) begin
         r = top;
      end else begin
         r = v - 7'd1;
      end
      return r;
   endfunction

   function automatic logic [6:0] clamp_to(input logic [6:0] v, input logic [6:0] top);
      return (v > top) ? top : v;
   endfunction

   function automatic logic [23:0] pack_time(input logic [6:0] h, input logic [6:0] m,
                                             input logic [6:0] s, input logic [6:0] c);
      return {h[4:0], m[5:0], s[5:0], c};
   endfunction

   logic [PW-1:0] presc_r, presc_nxt_s;
   logic [23:0]   time_r, time_nxt_s;
   logic [23:0]   lap_time_r;
   logic          lap_valid_r;
   logic          tick_r, upd_r, zero_pend_r, alarm_hit_r, zero_reached_r;

   logic [6:0]    hour_s, min_s, sec_s, csec_s;
   logic [6:0]    t_h_s, t_m_s, t_s_s, t_c_s;
   logic [6:0]    a_h_s, a_m_s, a_s_s;
   logic [23:0]   tick_time_s, adj_time_s, load_clamped_s;
   logic          tick_s, tick_fire_s, upd_s, freeze_s, set_act_s;
   logic          cur_zero_s, next_zero_s, alarm_match_s;

   assign hour_s = {2'b00, time_r[23:19]};
   assign min_s  = {1'b0, time_r[18:13]};
   assign sec_s  = {1'b0, time_r[12:7]};
   assign csec_s = time_r[6:0];

   assign tick_s      = tk.run & ~tk.set_en & (presc_r == PRE_LAST);
   assign tick_fire_s = tick_s & ~tk.clear & ~tk.load;
   assign cur_zero_s  = (time_r == 24'd0);
   assign freeze_s    = STOP_EN & tk.down & cur_zero_s;
   assign upd_s       = tick_fire_s & ~freeze_s;
   assign set_act_s   = tk.set_en & (tk.inc ^ tk.dec) & (tk.set_field != 2'd0);

   // Tick successor: full carry (up) or borrow (down) ripple across all fields.
   always_comb begin
      t_h_s = hour_s;
      t_m_s = min_s;
      t_s_s = sec_s;
      t_c_s = csec_s;
      if (tk.down) begin
         t_c_s = step_dn(csec_s, CSEC_TOP);
         if (csec_s == 7'd0) begin
            t_s_s = step_dn(sec_s, SEC_TOP);
            if (sec_s == 7'd0) begin
               t_m_s = step_dn(min_s, SEC_TOP);
               if (min_s == 7'd0) begin
                  t_h_s = step_dn(hour_s, HOUR_TOP);
               end else begin
                  t_h_s = hour_s;
               end
            end else begin
               t_m_s = min_s;
            end
         end else begin
            t_s_s = sec_s;
         end
      end else begin
         t_c_s = step_up(csec_s, CSEC_TOP);
         if (csec_s >= CSEC_TOP) begin
            t_s_s = step_up(sec_s, SEC_TOP);
            if (sec_s >= SEC_TOP) begin
               t_m_s = step_up(min_s, SEC_TOP);
               if (min_s >= SEC_TOP) begin
                  t_h_s = step_up(hour_s, HOUR_TOP);
               end else begin
                  t_h_s = hour_s;
               end
            end else begin
               t_m_s = min_s;
            end
         end else begin
            t_s_s = sec_s;
         end
      end
   end

   assign tick_time_s = pack_time(t_h_s, t_m_s, t_s_s, t_c_s);
   assign next_zero_s = (tick_time_s == 24'd0);

   // Set-mode adjust: selected field only, wraps within its own range, csec untouched.
   always_comb begin
      a_h_s = hour_s;
      a_m_s = min_s;
      a_s_s = sec_s;
      case (tk.set_field)
         2'd1: a_s_s = tk.inc ? step_up(sec_s, SEC_TOP)   : step_dn(sec_s, SEC_TOP);
         2'd2: a_m_s = tk.inc ? step_up(min_s, SEC_TOP)   : step_dn(min_s, SEC_TOP);
         2'd3: a_h_s = tk.inc ? step_up(hour_s, HOUR_TOP) : step_dn(hour_s, HOUR_TOP);
         default: a_s_s = sec_s;
      endcase
   end

   assign adj_time_s     = pack_time(a_h_s, a_m_s, a_s_s, csec_s);
   assign load_clamped_s = pack_time(clamp_to({2'b00, tk.load_time[23:19]}, HOUR_TOP),
                                     clamp_to({1'b0, tk.load_time[18:13]}, SEC_TOP),
                                     clamp_to({1'b0, tk.load_time[12:7]}, SEC_TOP),
                                     clamp_to(tk.load_time[6:0], CSEC_TOP));
   assign alarm_match_s  = (time_r[23:7] == tk.alarm_time) & (csec_s == 7'd0);

   // Next time value by priority clear > load > set adjust > tick.
   always_comb begin
      time_nxt_s = time_r;
      if (tk.clear) begin
         time_nxt_s = 24'd0;
      end else if (tk.load) begin
         time_nxt_s = load_clamped_s;
      end else if (set_act_s) begin
         time_nxt_s = adj_time_s;
      end else if (upd_s) begin
         time_nxt_s = tick_time_s;
      end else begin
         time_nxt_s = time_r;
      end
   end

   // Prescaler: restarts on clear/load, holds when stopped or in set mode.
   always_comb begin
      presc_nxt_s = presc_r;
      if (tk.clear || tk.load) begin
         presc_nxt_s = '0;
      end else if (tk.run && !tk.set_en) begin
         presc_nxt_s = (presc_r == PRE_LAST) ? '0 : presc_r + PW'(1);
      end else begin
         presc_nxt_s = presc_r;
      end
   end

   // State and output registers; event pulses trail their tick update by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_r        <= '0;
         time_r         <= 24'd0;
         lap_time_r     <= 24'd0;
         lap_valid_r    <= 1'b0;
         tick_r         <= 1'b0;
         upd_r          <= 1'b0;
         zero_pend_r    <= 1'b0;
         alarm_hit_r    <= 1'b0;
         zero_reached_r <= 1'b0;
      end else begin
         presc_r <= presc_nxt_s;
         time_r  <= time_nxt_s;
         if (tk.clear) begin
            lap_time_r     <= 24'd0;
            lap_valid_r    <= 1'b0;
            tick_r         <= 1'b0;
            upd_r          <= 1'b0;
            zero_pend_r    <= 1'b0;
            alarm_hit_r    <= 1'b0;
            zero_reached_r <= 1'b0;
         end else begin
            if (tk.lap) begin
               lap_time_r  <= time_r;
               lap_valid_r <= 1'b1;
            end
            tick_r         <= tick_fire_s;
            upd_r          <= upd_s;
            zero_pend_r    <= upd_s & STOP_EN & tk.down & ~cur_zero_s & next_zero_s;
            alarm_hit_r    <= upd_r & tk.alarm_en & alarm_match_s;
            zero_reached_r <= zero_pend_r;
         end
      end
   end

   assign tk.time_out     = time_r;
   assign tk.lap_time     = lap_time_r;
   assign tk.lap_valid    = lap_valid_r;
   assign tk.tick         = tick_r;
   assign tk.alarm_hit    = alarm_hit_r;
   assign tk.zero_reached = zero_reached_r;
endmodule

// File: tb/tb_timekeeper_core.sv
// Directed self-checking bench for timekeeper_core (DIV = 10): vector table plus multi-cycle sequences.
// A second instance with STOP_AT_ZERO=0 mirrors the same stimulus for the down-count wrap case.
module tb_timekeeper_core;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   timekeeper_core_if tk_s ();
   timekeeper_core_if tk_w ();

   timekeeper_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MAX(24), .STOP_AT_ZERO(1))
      dut_s (.clk(clk), .reset(reset), .tk(tk_s));
   timekeeper_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MAX(24), .STOP_AT_ZERO(0))
      dut_w (.clk(clk), .reset(reset), .tk(tk_w));

   assign tk_w.run        = tk_s.run;
   assign tk_w.down       = tk_s.down;
   assign tk_w.clear      = tk_s.clear;
   assign tk_w.load       = tk_s.load;
   assign tk_w.load_time  = tk_s.load_time;
   assign tk_w.set_en     = tk_s.set_en;
   assign tk_w.set_field  = tk_s.set_field;
   assign tk_w.inc        = tk_s.inc;
   assign tk_w.dec        = tk_s.dec;
   assign tk_w.lap        = tk_s.lap;
   assign tk_w.alarm_en   = tk_s.alarm_en;
   assign tk_w.alarm_time = tk_s.alarm_time;

   always #5 clk = ~clk;

   typedef struct {
      logic        clear;
      logic        load;
      logic [23:0] load_time;
      logic        set_en;
      logic [1:0]  set_field;
      logic        inc;
      logic        dec;
      logic        lap;
      logic [23:0] exp_time;
      logic        exp_lap_valid;
      logic [23:0] exp_lap_time;
   } vec_t;

   vec_t vecs[17];

   function automatic logic [23:0] tm(input int h, input int m, input int s, input int c);
      return {h[4:0], m[5:0], s[5:0], c[6:0]};
   endfunction

   function automatic vec_t mk(input logic clr, input logic ld, input logic [23:0] lt,
                               input logic se, input logic [1:0] sf, input logic i,
                               input logic d, input logic lp, input logic [23:0] et,
                               input logic elv, input logic [23:0] elt);
      vec_t v;
      v.clear = clr; v.load = ld; v.load_time = lt; v.set_en = se; v.set_field = sf;
      v.inc = i; v.dec = d; v.lap = lp;
      v.exp_time = et; v.exp_lap_valid = elv; v.exp_lap_time = elt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulses_off();
      tk_s.clear = 1'b0; tk_s.load = 1'b0; tk_s.set_en = 1'b0; tk_s.set_field = 2'd0;
      tk_s.inc = 1'b0; tk_s.dec = 1'b0; tk_s.lap = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " time_out"}, 32'(tk_s.time_out), 32'd0);
      check({tag, " lap_time"}, 32'(tk_s.lap_time), 32'd0);
      check({tag, " lap_valid"}, 32'(tk_s.lap_valid), 32'd0);
      check({tag, " tick"}, 32'(tk_s.tick), 32'd0);
      check({tag, " alarm_hit"}, 32'(tk_s.alarm_hit), 32'd0);
      check({tag, " zero_reached"}, 32'(tk_s.zero_reached), 32'd0);
   endtask

   // Counts rising edges until tick is seen (sampled 1 time unit after the edge); 0 = not seen.
   task automatic wait_tick(input int limit, output int n);
      n = 0;
      for (int k = 1; k <= limit; k++) begin
         @(posedge clk);
         #1;
         if (tk_s.tick) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      int n;
      int cnt;
      int early;
      int ticks;
      int zcnt;
      int zat;
      logic found;
      logic [23:0] wtime;

      pulses_off();
      tk_s.run = 1'b1; tk_s.down = 1'b0; tk_s.load_time = 24'd0;
      tk_s.alarm_en = 1'b0; tk_s.alarm_time = 17'd0;

      #22;
      check_all_zero("reset");

      // Free run from reset: first tick after DIV edges, then every DIV edges.
      @(negedge clk);
      reset = 1'b0;
      wait_tick(30, n);
      check("first tick latency", 32'(n), 32'd10);
      check("time after first tick", 32'(tk_s.time_out), 32'(tm(0, 0, 0, 1)));
      @(posedge clk);
      #1;
      check("tick width", 32'(tk_s.tick), 32'd0);
      wait_tick(30, n);
      check("second tick spacing", 32'(n), 32'd9);
      check("time after second tick", 32'(tk_s.time_out), 32'(tm(0, 0, 0, 2)));

      @(negedge clk);
      tk_s.load = 1'b1; tk_s.load_time = tm(23, 59, 59, 99);
      @(negedge clk);
      tk_s.load = 1'b0;
      check("load 23:59:59:99", 32'(tk_s.time_out), 32'(tm(23, 59, 59, 99)));
      wait_tick(30, n);
      check("tick after load", 32'(n), 32'd10);
      check("full carry rollover", 32'(tk_s.time_out), 32'd0);

      // Vector table: run=0, one cycle per vector.
      vecs[0]  = mk(1, 0, 24'd0, 0, 2'd0, 0, 0, 0, tm(0, 0, 0, 0), 0, 24'd0);
      vecs[1]  = mk(0, 1, tm(12, 34, 56, 78), 0, 2'd0, 0, 0, 0, tm(12, 34, 56, 78), 0, 24'd0);
      vecs[2]  = mk(0, 1, {5'd24, 6'd12, 6'd60, 7'd5}, 0, 2'd0, 0, 0, 0, tm(23, 12, 59, 5), 0, 24'd0);
      vecs[3]  = mk(0, 1, {5'd30, 6'd63, 6'd61, 7'd120}, 0, 2'd0, 0, 0, 0, tm(23, 59, 59, 99), 0, 24'd0);
      vecs[4]  = mk(0, 0, 24'd0, 1, 2'd2, 1, 0, 0, tm(23, 0, 59, 99), 0, 24'd0);
      vecs[5]  = mk(0, 0, 24'd0, 1, 2'd2, 0, 1, 0, tm(23, 59, 59, 99), 0, 24'd0);
      vecs[6]  = mk(0, 0, 24'd0, 1, 2'd2, 1, 1, 0, tm(23, 59, 59, 99), 0, 24'd0);
      vecs[7]  = mk(0, 0, 24'd0, 1, 2'd3, 1, 0, 0, tm(0, 59, 59, 99), 0, 24'd0);
      vecs[8]  = mk(0, 0, 24'd0, 1, 2'd1, 0, 1, 0, tm(0, 59, 58, 99), 0, 24'd0);
      vecs[9]  = mk(0, 0, 24'd0, 1, 2'd0, 1, 0, 0, tm(0, 59, 58, 99), 0, 24'd0);
      vecs[10] = mk(0, 0, 24'd0, 1, 2'd1, 1, 0, 0, tm(0, 59, 59, 99), 0, 24'd0);
      vecs[11] = mk(0, 0, 24'd0, 1, 2'd1, 1, 0, 0, tm(0, 59, 0, 99), 0, 24'd0);
      vecs[12] = mk(0, 1, tm(1, 2, 3, 4), 1, 2'd1, 1, 0, 0, tm(1, 2, 3, 4), 0, 24'd0);
      vecs[13] = mk(1, 1, tm(9, 9, 9, 9), 0, 2'd0, 0, 0, 0, tm(0, 0, 0, 0), 0, 24'd0);
      vecs[14] = mk(0, 1, tm(0, 0, 0, 37), 0, 2'd0, 0, 0, 1, tm(0, 0, 0, 37), 1, 24'd0);
      vecs[15] = mk(0, 0, 24'd0, 0, 2'd0, 0, 0, 1, tm(0, 0, 0, 37), 1, tm(0, 0, 0, 37));
      vecs[16] = mk(1, 0, 24'd0, 0, 2'd0, 0, 0, 1, tm(0, 0, 0, 0), 0, 24'd0);

      @(negedge clk);
      tk_s.run = 1'b0;
      for (int i = 0; i < 17; i++) begin
         tk_s.clear = vecs[i].clear; tk_s.load = vecs[i].load; tk_s.load_time = vecs[i].load_time;
         tk_s.set_en = vecs[i].set_en; tk_s.set_field = vecs[i].set_field;
         tk_s.inc = vecs[i].inc; tk_s.dec = vecs[i].dec; tk_s.lap = vecs[i].lap;
         @(negedge clk);
         check($sformatf("vec%0d time_out", i), 32'(tk_s.time_out), 32'(vecs[i].exp_time));
         check($sformatf("vec%0d lap_valid", i), 32'(tk_s.lap_valid), 32'(vecs[i].exp_lap_valid));
         check($sformatf("vec%0d lap_time", i), 32'(tk_s.lap_time), 32'(vecs[i].exp_lap_time));
      end
      pulses_off();

      // Prescaler holds across run=0 and set mode, then resumes from where it stopped.
      tk_s.clear = 1'b1;
      @(negedge clk);
      tk_s.clear = 1'b0; tk_s.run = 1'b1;
      repeat (4) @(negedge clk);
      tk_s.run = 1'b0;
      repeat (10) @(negedge clk);
      tk_s.run = 1'b1; tk_s.set_en = 1'b1; tk_s.set_field = 2'd2;
      cnt = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (tk_s.tick) cnt++;
      end
      check("no ticks in set mode", 32'(cnt), 32'd0);
      check("time held in set mode", 32'(tk_s.time_out), 32'd0);
      tk_s.set_en = 1'b0; tk_s.set_field = 2'd0;
      wait_tick(20, n);
      check("prescaler resume", 32'(n), 32'd6);
      check("time after resume", 32'(tk_s.time_out), 32'(tm(0, 0, 0, 1)));

      // Countdown to zero: freeze and single pulse on one instance, wrap on the other.
      @(negedge clk);
      tk_s.run = 1'b0; tk_s.down = 1'b1; tk_s.load = 1'b1; tk_s.load_time = tm(0, 0, 0, 2);
      @(negedge clk);
      tk_s.load = 1'b0; tk_s.run = 1'b1;
      ticks = 0; zcnt = 0; zat = -1; wtime = 24'hFFFFFF;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk);
         #1;
         if (tk_s.tick) begin
            ticks++;
            if (ticks == 3) wtime = tk_w.time_out;
         end
         if (tk_s.zero_reached) begin
            zcnt++;
            zat = ticks;
         end
      end
      check("tick count in countdown", 32'(ticks), 32'd8);
      check("zero_reached pulse count", 32'(zcnt), 32'd1);
      check("zero_reached after 2nd tick", 32'(zat), 32'd2);
      check("frozen at zero", 32'(tk_s.time_out), 32'd0);
      check("wrap without stop", 32'(wtime), 32'(tm(23, 59, 59, 99)));

      // Alarm on a tick-driven match, silent on load and when masked.
      @(negedge clk);
      tk_s.run = 1'b0; tk_s.down = 1'b0; tk_s.clear = 1'b1;
      @(negedge clk);
      tk_s.clear = 1'b0; tk_s.alarm_en = 1'b1; tk_s.alarm_time = {5'd0, 6'd0, 6'd1}; tk_s.run = 1'b1;
      early = 0; found = 1'b0;
      for (int k = 0; k < 1100; k++) begin
         @(posedge clk);
         #1;
         if (tk_s.alarm_hit) early++;
         if (tk_s.time_out == tm(0, 0, 1, 0)) begin
            found = 1'b1;
            break;
         end
      end
      check("reached 00:00:01:00", 32'(found), 32'd1);
      check("no early alarm", 32'(early), 32'd0);
      check("alarm not with time", 32'(tk_s.alarm_hit), 32'd0);
      @(posedge clk);
      #1;
      check("alarm pulse", 32'(tk_s.alarm_hit), 32'd1);
      @(posedge clk);
      #1;
      check("alarm pulse width", 32'(tk_s.alarm_hit), 32'd0);

      @(negedge clk);
      tk_s.run = 1'b0; tk_s.load = 1'b1; tk_s.load_time = tm(0, 0, 1, 0);
      @(negedge clk);
      tk_s.load = 1'b0;
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (tk_s.alarm_hit) cnt++;
      end
      check("no alarm on load", 32'(cnt), 32'd0);

      tk_s.alarm_en = 1'b0; tk_s.load = 1'b1; tk_s.load_time = tm(0, 0, 0, 99);
      @(negedge clk);
      tk_s.load = 1'b0; tk_s.run = 1'b1;
      wait_tick(15, n);
      check("masked alarm tick", 32'(n), 32'd10);
      check("masked alarm time", 32'(tk_s.time_out), 32'(tm(0, 0, 1, 0)));
      @(posedge clk);
      #1;
      check("alarm masked", 32'(tk_s.alarm_hit), 32'd0);

      // Asynchronous reset in the middle of a running count.
      @(negedge clk);
      tk_s.run = 1'b0; tk_s.load = 1'b1; tk_s.load_time = tm(5, 6, 7, 8);
      @(negedge clk);
      tk_s.load = 1'b0; tk_s.lap = 1'b1;
      @(negedge clk);
      tk_s.lap = 1'b0; tk_s.run = 1'b1;
      check("lap before reset valid", 32'(tk_s.lap_valid), 32'd1);
      check("lap before reset time", 32'(tk_s.lap_time), 32'(tm(5, 6, 7, 8)));
      repeat (13) @(negedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_all_zero("async reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
